// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master I/O bus arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [31:0] HEX_ADDR          = 32'hF000_0000;
    localparam logic [31:0] LEDR_ADDR         = 32'hF000_0004;
    localparam logic [31:0] LEDG_ADDR         = 32'hF000_0008;
    localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/io_arb_rr_pick.sv
// Two-way round-robin picker with an optional hold-current-owner override.
module io_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock_en,
    input  logic       lock_owner,
    output logic       grant_c
);

    // Tie goes to whichever requester did not win last time.
    always_comb begin
        grant_c = 1'b0;
        if (lock_en && req[lock_owner]) begin
            grant_c = lock_owner;
        end else begin
            case (req)
                2'b10:   grant_c = 1'b1;
                2'b11:   grant_c = ~last_grant;
                default: grant_c = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates two masters onto the aBus/dBus/wrtEn device bus, one access per IDLE->BUS->ACK pass.
// Optional bus locking is built when IO_ARB_LOCK_EN is defined.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned ABUS_WIDTH = 32,
    parameter int unsigned DBUS_WIDTH = 32,
    parameter logic [ABUS_WIDTH-1:0] IDLE_ADDR = ABUS_WIDTH'(DEFAULT_IDLE_ADDR)
`ifdef IO_ARB_LOCK_EN
    ,
    parameter int unsigned LOCK_MAX = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ABUS_WIDTH-1:0] addr0,
    input  logic [ABUS_WIDTH-1:0] addr1,
    input  logic [DBUS_WIDTH-1:0] wdata0,
    input  logic [DBUS_WIDTH-1:0] wdata1,
`ifdef IO_ARB_LOCK_EN
    input  logic                  lock0,
    input  logic                  lock1,
`endif
    output logic                  ack0,
    output logic                  ack1,
    output logic [DBUS_WIDTH-1:0] rdata0,
    output logic [DBUS_WIDTH-1:0] rdata1,
    output logic [ABUS_WIDTH-1:0] aBus,
    inout  tri   [DBUS_WIDTH-1:0] dBus,
    output logic                  wrtEn,
    output logic                  busy
);

    state_t                state_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  drive_q;
    logic [DBUS_WIDTH-1:0] wdata_q;
    logic                  grant_c;
    logic                  lock_ovr_c;

`ifdef IO_ARB_LOCK_EN
    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

    logic           lock_hold_q;
    logic [LCW-1:0] lock_cnt_q;

    // Lock is honoured only until the owner has used up its consecutive-grant budget.
    assign lock_ovr_c = lock_hold_q && (lock_cnt_q < LCW'(LOCK_MAX));
`else
    assign lock_ovr_c = 1'b0;
`endif

    io_arb_rr_pick u_pick (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .lock_en    (lock_ovr_c),
        .lock_owner (owner_q),
        .grant_c    (grant_c)
    );

    // Only a write bus phase drives the shared data lines.
    assign dBus = drive_q ? wdata_q : {DBUS_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            drive_q      <= 1'b0;
            wdata_q      <= '0;
            aBus         <= IDLE_ADDR;
            wrtEn        <= 1'b0;
            busy         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
`ifdef IO_ARB_LOCK_EN
            lock_hold_q  <= 1'b0;
            lock_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        owner_q      <= grant_c;
                        last_grant_q <= grant_c;
                        aBus         <= grant_c ? addr1 : addr0;
                        wrtEn        <= grant_c ? we1 : we0;
                        drive_q      <= grant_c ? we1 : we0;
                        wdata_q      <= grant_c ? wdata1 : wdata0;
                        busy         <= 1'b1;
                        state_q      <= BUS;
`ifdef IO_ARB_LOCK_EN
                        if (lock_ovr_c && (grant_c == owner_q)) begin
                            lock_cnt_q <= lock_cnt_q + LCW'(1);
                        end else begin
                            lock_cnt_q <= '0;
                        end
`endif
                    end
`ifdef IO_ARB_LOCK_EN
                    lock_hold_q <= 1'b0;
`endif
                end
                BUS: begin
                    if (!wrtEn) begin
                        if (owner_q) begin
                            rdata1 <= dBus;
                        end else begin
                            rdata0 <= dBus;
                        end
                    end
                    aBus    <= IDLE_ADDR;
                    wrtEn   <= 1'b0;
                    drive_q <= 1'b0;
                    ack0    <= ~owner_q;
                    ack1    <= owner_q;
                    state_q <= ACK;
                end
                ACK: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
`ifdef IO_ARB_LOCK_EN
                    lock_hold_q <= owner_q ? lock1 : lock0;
`endif
                end
                default: begin
                    aBus    <= IDLE_ADDR;
                    wrtEn   <= 1'b0;
                    drive_q <= 1'b0;
                    busy    <= 1'b0;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a HEX/LEDR/LEDG register model on the device bus.
// Define IO_ARB_LOCK_EN to also exercise the lock path (LOCK_MAX = 2).
module tb_io_bus_arbiter;
    import io_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        lock0, lock1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] aBus;
    tri   [31:0] dBus;
    logic        wrtEn, busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] hex_q, ledr_q, ledg_q;
    logic        dev_hit;
    logic [31:0] dev_rd;

    always #5 clk = ~clk;

    io_bus_arbiter #(
        .ABUS_WIDTH(32),
        .DBUS_WIDTH(32)
`ifdef IO_ARB_LOCK_EN
        , .LOCK_MAX(2)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
`ifdef IO_ARB_LOCK_EN
        .lock0  (lock0),
        .lock1  (lock1),
`endif
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .aBus   (aBus),
        .dBus   (dBus),
        .wrtEn  (wrtEn),
        .busy   (busy)
    );

    // Device register model: written on wrtEn, driven onto dBus on a read cycle.
    always @(posedge clk) begin
        if (reset) begin
            hex_q  <= 32'h0;
            ledr_q <= 32'h0;
            ledg_q <= 32'h0;
        end else if (wrtEn) begin
            if (aBus == HEX_ADDR)  hex_q  <= dBus;
            if (aBus == LEDR_ADDR) ledr_q <= dBus;
            if (aBus == LEDG_ADDR) ledg_q <= dBus;
        end
    end

    always_comb begin
        dev_hit = 1'b0;
        dev_rd  = 32'h0;
        if (aBus == HEX_ADDR)  begin dev_hit = 1'b1; dev_rd = hex_q;  end
        if (aBus == LEDR_ADDR) begin dev_hit = 1'b1; dev_rd = ledr_q; end
        if (aBus == LEDG_ADDR) begin dev_hit = 1'b1; dev_rd = ledg_q; end
    end

    assign dBus = (dev_hit && !wrtEn) ? dev_rd : 32'hzzzz_zzzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Single access by one master; reports latency, write-enable cycles, bus address in BUS, rdata at ack.
    task automatic access(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int wr_cycles, output logic [31:0] a_obs,
                          output logic [31:0] rd_ack);
        if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        lat = 0; wr_cycles = 0; a_obs = 32'h0; rd_ack = 32'h0;
        do begin
            tick();
            lat++;
            if (wrtEn) wr_cycles++;
            if (lat == 1) a_obs = aBus;
        end while (!(who ? ack1 : ack0) && lat < 10);
        rd_ack = who ? rdata1 : rdata0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    int          lat, wrc;
    logic [31:0] a_obs, rd;
    int          ev_who [4];
    int          ev_t   [4];
    int          n_ev;

    task automatic record_acks(input int budget);
        n_ev = 0;
        for (int i = 0; i < 4; i++) begin ev_who[i] = -1; ev_t[i] = -100; end
        for (int t = 0; t < budget && n_ev < 4; t++) begin
            tick();
            if (ack0 && n_ev < 4) begin ev_who[n_ev] = 0; ev_t[n_ev] = t; n_ev++; end
            if (ack1 && n_ev < 4) begin ev_who[n_ev] = 1; ev_t[n_ev] = t; n_ev++; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        lock0 = 1'b0; lock1 = 1'b0;
        do_reset();

        check("rst_abus",   aBus,   32'h0);
        check("rst_wrten",  32'(wrtEn), 32'h0);
        check("rst_ack",    {30'h0, ack1, ack0}, 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_busy",   32'(busy), 32'h0);

        // Write LEDR through requester 0.
        access(1'b0, 1'b1, LEDR_ADDR, 32'h2AA, lat, wrc, a_obs, rd);
        check("wr_lat",     32'(lat), 32'd2);
        check("wr_wrten",   32'(wrc), 32'd1);
        check("wr_abus",    a_obs, LEDR_ADDR);
        check("wr_ledr",    ledr_q, 32'h2AA);
        check("wr_rdata0",  rdata0, 32'h0);
        check("wr_ack_off", {30'h0, ack1, ack0}, 32'h0);
        check("wr_busy",    32'(busy), 32'h0);
        check("wr_idle_ab", aBus, 32'h0);

        // HEX write by requester 0, then read back by requester 1.
        access(1'b0, 1'b1, HEX_ADDR, 32'hBEEF, lat, wrc, a_obs, rd);
        check("hex_wr",     hex_q, 32'hBEEF);
        access(1'b1, 1'b0, HEX_ADDR, 32'h0, lat, wrc, a_obs, rd);
        check("rd1_lat",    32'(lat), 32'd2);
        check("rd1_wrten",  32'(wrc), 32'd0);
        check("rd1_abus",   a_obs, HEX_ADDR);
        check("rd1_at_ack", rd, 32'h0000_BEEF);
        check("rd1_rdata0", rdata0, 32'h0);
        check("rd1_hold",   rdata1, 32'h0000_BEEF);

        // Requester 0 reads LEDR; requester 1 writes LEDG and must keep its old rdata.
        access(1'b0, 1'b0, LEDR_ADDR, 32'h0, lat, wrc, a_obs, rd);
        check("rd0_at_ack", rd, 32'h2AA);
        check("rd0_rdata1", rdata1, 32'h0000_BEEF);
        access(1'b1, 1'b1, LEDG_ADDR, 32'h1234_5678, lat, wrc, a_obs, rd);
        check("wr1_ledg",   ledg_q, 32'h1234_5678);
        check("wr1_rdata1", rdata1, 32'h0000_BEEF);
        access(1'b0, 1'b0, LEDG_ADDR, 32'h0, lat, wrc, a_obs, rd);
        check("rd0_ledg",   rd, 32'h1234_5678);

        // Contention from reset: both masters read continuously.
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = LEDR_ADDR;
        req1 = 1'b1; we1 = 1'b0; addr1 = HEX_ADDR;
        repeat (2) tick();
        reset = 1'b0;
        record_acks(20);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("rr_who%0d", i), 32'(ev_who[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), 32'(ev_t[i] - ev_t[i-1]), 32'd3);
        repeat (3) tick();

        // Reset during the BUS phase of a write drops it with no ack.
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = LEDG_ADDR; wdata0 = 32'h55;
        tick();
        check("mid_busy",   32'(busy), 32'h1);
        check("mid_wrten",  32'(wrtEn), 32'h1);
        reset = 1'b1;
        req0  = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_ack",    {30'h0, ack1, ack0}, 32'h0);
        check("mid_busy0",  32'(busy), 32'h0);
        tick();
        check("mid_ack2",   {30'h0, ack1, ack0}, 32'h0);
        check("mid_ledg",   ledg_q, 32'h0);
        access(1'b0, 1'b1, LEDG_ADDR, 32'h77, lat, wrc, a_obs, rd);
        check("post_lat",   32'(lat), 32'd2);
        check("post_ledg",  ledg_q, 32'h77);

`ifdef IO_ARB_LOCK_EN
        // Requester 0 locks; after two locked grants the bus is released to requester 1.
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = LEDR_ADDR; lock0 = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = HEX_ADDR;
        repeat (2) tick();
        reset = 1'b0;
        record_acks(30);
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        check("lock_who0", 32'(ev_who[0]), 32'd0);
        check("lock_who1", 32'(ev_who[1]), 32'd0);
        check("lock_who2", 32'(ev_who[2]), 32'd0);
        check("lock_who3", 32'(ev_who[3]), 32'd1);
        repeat (3) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
